// File: rtl/ber_checker_pkg.sv
// Shared constants, FSM encoding and tap helper for the PRBS9 BER checker.
// Every tap/window register is one PRBS9 period wide (0..510).
package ber_checker_pkg;

    localparam int unsigned PRBS9_LEN = 511;
    localparam int unsigned NB_DELAY  = 9;

    localparam logic [NB_DELAY-1:0] LAST_TAP = 9'd510;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Next candidate delay, wrapping 510 -> 0.
    function automatic logic [NB_DELAY-1:0] next_tap(input logic [NB_DELAY-1:0] tap);
        return (tap == LAST_TAP) ? '0 : tap + 9'd1;
    endfunction

endpackage

// File: rtl/ber_checker_prbs9.sv
// PRBS9 generator (x^9 + x^5 + 1), one bit per enable, active-high async reset to SEED.
module ber_checker_prbs9 #(
    parameter logic [8:0] SEED = 9'h1AA
) (
    input  logic clock,
    input  logic i_reset,
    input  logic i_enable,
    output logic o_bit
);

    logic [8:0] r_sr;

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            r_sr <= SEED;
        end else if (i_enable) begin
            r_sr <= {r_sr[7:0], r_sr[8] ^ r_sr[4]};
        end
    end

    assign o_bit = r_sr[8];

endmodule

// File: rtl/ber_checker.sv
// BER checker: picks one sample per baud, slices by sign, aligns to a local PRBS9
// by exhaustive delay search, then accumulates error and bit counts.
module ber_checker
    import ber_checker_pkg::*;
#(
    parameter int unsigned NB_DATA    = 8,
    parameter int unsigned OS         = 4,
    parameter logic [8:0]  SEED       = 9'h1AA,
    parameter int unsigned NB_COUNT   = 64,
    parameter int unsigned ERR_THRESH = 64
) (
    input  logic                       clock,
    input  logic                       i_reset,
    input  logic                       i_enable,
    input  logic                       i_valid,
    input  logic signed [NB_DATA-1:0]  i_data,
    input  logic [1:0]                 i_phase,
    output logic                       o_locked,
    output logic                       o_ber_zero,
    output logic [NB_DELAY-1:0]        o_delay,
    output logic [NB_COUNT-1:0]        o_err_count,
    output logic [NB_COUNT-1:0]        o_bit_count
);

    localparam logic [1:0] LAST_PHASE = 2'(OS - 1);

    state_t                r_state, w_state_d;
    logic [1:0]            r_phase_cnt;
    logic [PRBS9_LEN-1:0]  r_ref_sr;
    logic [NB_DELAY-1:0]   r_delay, w_delay_d;
    logic [NB_DELAY-1:0]   r_win_cnt, w_win_cnt_d;
    logic [NB_DELAY-1:0]   r_win_err, w_win_err_d;
    logic [NB_COUNT-1:0]   r_err_count, w_err_count_d;
    logic [NB_COUNT-1:0]   r_bit_count, w_bit_count_d;
    logic                  r_locked;
    logic                  r_ber_zero;

    logic                  w_dec;
    logic                  w_rx_bit;
    logic                  w_err;
    logic                  w_prbs_bit;
    logic                  w_win_end;
    logic [NB_DELAY:0]     w_win_err_sum;
    logic [NB_DELAY-1:0]   w_win_err_sat;
    logic                  w_unused_data;

    assign w_dec         = i_valid & i_enable & (r_phase_cnt == i_phase);
    assign w_rx_bit      = ~i_data[NB_DATA-1];
    assign w_err         = w_rx_bit ^ r_ref_sr[r_delay];
    assign w_win_end     = w_dec && (r_win_cnt == LAST_TAP);
    assign w_unused_data = ^i_data[NB_DATA-2:0];

    // Window error total including the current decision.
    assign w_win_err_sum = {1'b0, r_win_err} + {{NB_DELAY{1'b0}}, w_err};
    assign w_win_err_sat = w_win_err_sum[NB_DELAY] ? '1 : w_win_err_sum[NB_DELAY-1:0];

    ber_checker_prbs9 #(
        .SEED (SEED)
    ) u_prbs9 (
        .clock    (clock),
        .i_reset  (~i_reset),
        .i_enable (w_dec),
        .o_bit    (w_prbs_bit)
    );

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_phase_cnt <= '0;
            r_ref_sr    <= '0;
        end else begin
            if (i_valid && i_enable) begin
                r_phase_cnt <= (r_phase_cnt == LAST_PHASE) ? 2'd0 : r_phase_cnt + 2'd1;
            end
            if (w_dec) begin
                r_ref_sr <= {r_ref_sr[PRBS9_LEN-2:0], w_prbs_bit};
            end
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_delay_d     = r_delay;
        w_err_count_d = r_err_count;
        w_bit_count_d = r_bit_count;
        w_win_cnt_d   = r_win_cnt;
        w_win_err_d   = r_win_err;

        if (w_dec) begin
            w_win_cnt_d = w_win_end ? '0 : r_win_cnt + 9'd1;
            w_win_err_d = w_win_end ? '0 : w_win_err_sat;
        end

        unique case (r_state)
            ST_IDLE: begin
                w_win_cnt_d = '0;
                w_win_err_d = '0;
                if (i_enable) begin
                    w_state_d = ST_SEARCH;
                    w_delay_d = '0;
                end
            end
            ST_SEARCH: begin
                if (!i_enable) begin
                    w_state_d = ST_IDLE;
                end else if (w_win_end) begin
                    if (w_win_err_sum == '0) begin
                        w_state_d     = ST_LOCKED;
                        w_err_count_d = '0;
                        w_bit_count_d = '0;
                    end else begin
                        w_delay_d = next_tap(r_delay);
                    end
                end
            end
            ST_LOCKED: begin
                if (!i_enable) begin
                    w_state_d = ST_IDLE;
                end else if (w_dec) begin
                    if (r_bit_count != '1) begin
                        w_bit_count_d = r_bit_count + 1'b1;
                    end
                    if (w_err && (r_err_count != '1)) begin
                        w_err_count_d = r_err_count + 1'b1;
                    end
                    if (w_win_end && (w_win_err_sum > (NB_DELAY+1)'(ERR_THRESH))) begin
                        w_state_d = ST_SEARCH;
                        w_delay_d = next_tap(r_delay);
                    end
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= ST_IDLE;
            r_delay     <= '0;
            r_win_cnt   <= '0;
            r_win_err   <= '0;
            r_err_count <= '0;
            r_bit_count <= '0;
            r_locked    <= 1'b0;
            r_ber_zero  <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_delay     <= w_delay_d;
            r_win_cnt   <= w_win_cnt_d;
            r_win_err   <= w_win_err_d;
            r_err_count <= w_err_count_d;
            r_bit_count <= w_bit_count_d;
            r_locked    <= (w_state_d == ST_LOCKED);
            r_ber_zero  <= (w_state_d == ST_LOCKED) && (w_err_count_d == '0);
        end
    end

    assign o_locked    = r_locked;
    assign o_ber_zero  = r_ber_zero;
    assign o_delay     = r_delay;
    assign o_err_count = r_err_count;
    assign o_bit_count = r_bit_count;

endmodule

// File: tb/tb_ber_checker.sv
// Directed bench for ber_checker: TX stream is the seed's PRBS9 delayed by 3 decisions,
// so the search must lock on tap 2 at the end of the third window.
module tb_ber_checker;

    localparam int unsigned NB_DATA  = 8;
    localparam int unsigned OS       = 4;
    localparam int unsigned NB_COUNT = 64;
    localparam logic [8:0]  SEED     = 9'h1AA;
    localparam int          LOCK_K   = 1533;

    logic                      clock    = 1'b0;
    logic                      i_reset  = 1'b0;
    logic                      i_enable = 1'b0;
    logic                      i_valid  = 1'b0;
    logic signed [NB_DATA-1:0] i_data   = '0;
    logic [1:0]                i_phase  = 2'd0;
    logic                      o_locked;
    logic                      o_ber_zero;
    logic [8:0]                o_delay;
    logic [NB_COUNT-1:0]       o_err_count;
    logic [NB_COUNT-1:0]       o_bit_count;

    int checks   = 0;
    int failures = 0;
    bit p [511];
    int k  = 0;
    int pc = 0;
    int zeros;
    bit ok;

    ber_checker #(
        .NB_DATA    (NB_DATA),
        .OS         (OS),
        .SEED       (SEED),
        .NB_COUNT   (NB_COUNT),
        .ERR_THRESH (64)
    ) dut (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_enable    (i_enable),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .i_phase     (i_phase),
        .o_locked    (o_locked),
        .o_ber_zero  (o_ber_zero),
        .o_delay     (o_delay),
        .o_err_count (o_err_count),
        .o_bit_count (o_bit_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"}, 64'(o_locked), 64'd0);
        check({tag, "_berzero"}, 64'(o_ber_zero), 64'd0);
        check({tag, "_delay"}, 64'(o_delay), 64'd0);
        check({tag, "_errcnt"}, o_err_count, 64'd0);
        check({tag, "_bitcnt"}, o_bit_count, 64'd0);
    endtask

    // One filter-output sample; the decided sample of baud k carries p[k-3].
    task automatic send(input bit flip, input bit cst);
        bit b;
        bit is_dec;
        b      = cst ? 1'b1 : p[(k + 508) % 511];
        is_dec = i_enable && (pc == int'(i_phase));
        if (is_dec && flip) b = ~b;
        i_data  = b ? 8'sd64 : -8'sd64;
        i_valid = 1'b1;
        tick();
        if (is_dec) k++;
        if (i_enable) pc = (pc + 1) % OS;
    endtask

    task automatic wait_lock(output bit got_lock);
        int n;
        n = 0;
        while (o_locked !== 1'b1 && n < 8000) begin
            send(1'b0, 1'b0);
            n++;
        end
        got_lock = (o_locked === 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 9; i++) p[i] = SEED[8-i];
        for (int n = 9; n < 511; n++) p[n] = p[n-9] ^ p[n-5];
        zeros = 0;
        for (int n = 0; n < 511; n++) if (!p[n]) zeros++;

        // Reset held: inputs toggling must not disturb anything.
        for (int i = 0; i < 6; i++) begin
            i_enable = i[0];
            i_valid  = i[1];
            i_data   = i[0] ? 8'sd64 : -8'sd64;
            tick();
        end
        check_all_zero("rst_hold");
        @(negedge clock);
        i_reset  = 1'b1;
        i_enable = 1'b0;
        i_valid  = 1'b0;
        tick();
        tick();
        check_all_zero("idle");

        // Enable with no sample in the IDLE cycle, so decision 0 opens window 0.
        i_enable = 1'b1;
        tick();
        while (k < 600) send(1'b0, 1'b0);
        check("search_tap1", 64'(o_delay), 64'd1);
        check("search_unlocked", 64'(o_locked), 64'd0);
        wait_lock(ok);
        check("lock1_found", 64'(ok), 64'd1);
        check("lock1_dec", 64'(k), 64'(LOCK_K));
        check("lock1_delay", 64'(o_delay), 64'd2);
        check("lock1_errcnt", o_err_count, 64'd0);
        check("lock1_bitcnt", o_bit_count, 64'd0);
        check("lock1_berzero", 64'(o_ber_zero), 64'd1);

        while (k < LOCK_K + 40) send(1'b0, 1'b0);
        check("bitcnt_40", o_bit_count, 64'd40);
        for (int i = 0; i < OS; i++) send(1'b0, 1'b0);
        check("bitcnt_per_baud", o_bit_count, 64'd41);

        // Three sign-flipped decisions: counted, but far below the relock threshold.
        while (k < 1700) send((k == 1580) || (k == 1620) || (k == 1660), 1'b0);
        check("inj_errcnt", o_err_count, 64'd3);
        check("inj_berzero", 64'(o_ber_zero), 64'd0);
        check("inj_locked", 64'(o_locked), 64'd1);
        check("inj_bitcnt", o_bit_count, 64'(1700 - LOCK_K));

        // Asynchronous reset pulse mid-lock clears outputs without a clock edge.
        i_reset = 1'b0;
        #1;
        check_all_zero("rst_pulse");
        @(negedge clock);
        i_reset = 1'b1;
        k       = 0;
        pc      = 0;
        i_valid = 1'b0;
        i_phase = 2'd1;
        tick();
        wait_lock(ok);
        check("lock2_found", 64'(ok), 64'd1);
        check("lock2_dec", 64'(k), 64'(LOCK_K));
        check("lock2_delay", 64'(o_delay), 64'd2);

        // One full window of constant +64: every ref zero is an error, forcing relock.
        while (k < LOCK_K + 510) send(1'b0, 1'b1);
        check("const_still_locked", 64'(o_locked), 64'd1);
        send(1'b0, 1'b1);
        while (k < LOCK_K + 511) send(1'b0, 1'b1);
        check("unlock_locked", 64'(o_locked), 64'd0);
        check("unlock_delay", 64'(o_delay), 64'd3);
        check("unlock_errcnt", o_err_count, 64'(zeros));
        check("unlock_bitcnt", o_bit_count, 64'd511);
        check("unlock_berzero", 64'(o_ber_zero), 64'd0);

        // Disable: counters and tap frozen, lock dropped.
        i_enable = 1'b0;
        for (int i = 0; i < 8; i++) send(1'b0, 1'b0);
        check("dis_locked", 64'(o_locked), 64'd0);
        check("dis_delay", 64'(o_delay), 64'd3);
        check("dis_errcnt", o_err_count, 64'(zeros));
        check("dis_bitcnt", o_bit_count, 64'd511);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
